// File: rtl/display_timings_tv.sv
// Parametrised TV raster timing generator: counters, syncs, paper/border qualifiers,
// frame interrupt and flash phase, with two geometries switched at frame wrap.
module display_timings_tv #(
  parameter int unsigned CORDW     = 11,
  parameter int unsigned H_TOTAL0  = 448,
  parameter int unsigned V_TOTAL0  = 312,
  parameter int unsigned H_TOTAL1  = 456,
  parameter int unsigned V_TOTAL1  = 311,
  parameter int unsigned H_RES     = 256,
  parameter int unsigned V_RES     = 192,
  parameter int unsigned H_PAPER   = 134,
  parameter int unsigned V_PAPER   = 80,
  parameter int unsigned H_DE      = 89,
  parameter int unsigned V_DE      = 33,
  parameter int unsigned HS_STA    = 11,
  parameter int unsigned HS_LEN    = 33,
  parameter int unsigned VS_STA    = 8,
  parameter int unsigned VS_LEN    = 4,
  parameter int unsigned INT_X     = 0,
  parameter int unsigned INT_Y     = 0,
  parameter int unsigned INT_LEN   = 32,
  parameter int unsigned FLASH_DIV = 16,
  parameter int unsigned H_POL     = 1,
  parameter int unsigned V_POL     = 1
) (
  input  logic                    clk_pix,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    mode,
  output logic                    mode_act,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    csync,
  output logic                    de,
  output logic                    screen,
  output logic                    border,
  output logic                    frame,
  output logic                    line,
  output logic                    int_n,
  output logic                    flash,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy
);

  localparam int unsigned IW = $clog2(INT_LEN + 1);
  localparam int unsigned FW = $clog2(FLASH_DIV + 1);

  localparam logic [CORDW-1:0] HT0_M1 = CORDW'(H_TOTAL0 - 1);
  localparam logic [CORDW-1:0] VT0_M1 = CORDW'(V_TOTAL0 - 1);
  localparam logic [CORDW-1:0] HT1_M1 = CORDW'(H_TOTAL1 - 1);
  localparam logic [CORDW-1:0] VT1_M1 = CORDW'(V_TOTAL1 - 1);
  localparam logic [CORDW-1:0] HP_S   = CORDW'(H_PAPER);
  localparam logic [CORDW-1:0] HP_E   = CORDW'(H_PAPER + H_RES);
  localparam logic [CORDW-1:0] VP_S   = CORDW'(V_PAPER);
  localparam logic [CORDW-1:0] VP_E   = CORDW'(V_PAPER + V_RES);
  localparam logic [CORDW-1:0] HDE_S  = CORDW'(H_DE);
  localparam logic [CORDW-1:0] VDE_S  = CORDW'(V_DE);
  localparam logic [CORDW-1:0] HS_S   = CORDW'(HS_STA);
  localparam logic [CORDW-1:0] HS_E   = CORDW'(HS_STA + HS_LEN);
  localparam logic [CORDW-1:0] VS_S   = CORDW'(VS_STA);
  localparam logic [CORDW-1:0] VS_E   = CORDW'(VS_STA + VS_LEN);
  localparam logic [CORDW-1:0] INT_XC = CORDW'(INT_X);
  localparam logic [CORDW-1:0] INT_YC = CORDW'(INT_Y);
  localparam logic             HPOL   = (H_POL != 0);
  localparam logic             VPOL   = (V_POL != 0);

  logic [CORDW-1:0] x, y, x_nx, y_nx, ht_m1, vt_m1;
  logic             last_x, last_y, wrap, hs_act, vs_act, de_c, screen_c, int_hit;
  logic [IW-1:0]    int_cnt, int_cnt_nx;
  logic [FW-1:0]    fcnt;

  // Next raster position and combinational qualifiers for the current position.
  always_comb begin
    ht_m1      = mode_act ? HT1_M1 : HT0_M1;
    vt_m1      = mode_act ? VT1_M1 : VT0_M1;
    last_x     = (x == ht_m1);
    last_y     = (y == vt_m1);
    wrap       = last_x && last_y;
    x_nx       = last_x ? '0 : x + CORDW'(1);
    y_nx       = y;
    if (last_x) y_nx = last_y ? '0 : y + CORDW'(1);
    hs_act     = (x >= HS_S) && (x < HS_E);
    vs_act     = (y >= VS_S) && (y < VS_E);
    de_c       = (x >= HDE_S) && (y >= VDE_S);
    screen_c   = (x >= HP_S) && (x < HP_E) && (y >= VP_S) && (y < VP_E);
    int_hit    = (x == INT_XC) && (y == INT_YC);
    int_cnt_nx = '0;
    if (int_hit)             int_cnt_nx = IW'(INT_LEN);
    else if (int_cnt != '0)  int_cnt_nx = int_cnt - IW'(1);
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      mode_act <= mode;
      hsync    <= ~HPOL;
      vsync    <= ~VPOL;
      csync    <= 1'b1;
      de       <= 1'b0;
      screen   <= 1'b0;
      border   <= 1'b0;
      frame    <= 1'b0;
      line     <= 1'b0;
      int_n    <= 1'b1;
      flash    <= 1'b0;
      sx       <= '0;
      sy       <= '0;
      int_cnt  <= '0;
      fcnt     <= '0;
    end else if (clk_en) begin
      x        <= x_nx;
      y        <= y_nx;
      if (wrap) mode_act <= mode;
      hsync    <= HPOL ? hs_act : ~hs_act;
      vsync    <= VPOL ? vs_act : ~vs_act;
      csync    <= ~(hs_act ^ vs_act);
      de       <= de_c;
      screen   <= screen_c;
      border   <= de_c && !screen_c;
      frame    <= (x == '0) && (y == '0);
      line     <= (x == '0);
      sx       <= x - HP_S;
      sy       <= y - VP_S;
      int_cnt  <= int_cnt_nx;
      int_n    <= (int_cnt_nx == '0);
      // Flash phase flips on every FLASH_DIV-th frame event.
      if ((x == '0) && (y == '0)) begin
        if (fcnt == FW'(FLASH_DIV - 1)) begin
          fcnt  <= '0;
          flash <= ~flash;
        end else begin
          fcnt  <= fcnt + FW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_display_timings_tv.sv
// Scoreboard bench for display_timings_tv on a reduced raster, with a position/timestamp model.
module tb_display_timings_tv;

  localparam int CORDW = 11;
  localparam int HT0 = 40, VT0 = 20, HT1 = 44, VT1 = 19;
  localparam int H_RES = 16, V_RES = 8, H_PAPER = 20, V_PAPER = 8;
  localparam int H_DE = 12, V_DE = 4;
  localparam int HS_STA = 2, HS_LEN = 5, VS_STA = 1, VS_LEN = 2;
  localparam int INT_X = 30, INT_Y = 18, INT_LEN = 60;
  localparam int FLASH_DIV = 3;
  localparam int H_POL = 0, V_POL = 1;

  typedef struct packed {
    logic mode_act, hsync, vsync, csync, de, screen, border, frame, line, int_n, flash;
    logic [CORDW-1:0] sx, sy;
  } out_t;

  logic clk_pix = 1'b0;
  logic rst_n, clk_en, mode;
  logic mode_act, hsync, vsync, csync, de, screen, border, frame, line, int_n, flash;
  logic signed [CORDW-1:0] sx, sy;

  display_timings_tv #(
    .CORDW(CORDW), .H_TOTAL0(HT0), .V_TOTAL0(VT0), .H_TOTAL1(HT1), .V_TOTAL1(VT1),
    .H_RES(H_RES), .V_RES(V_RES), .H_PAPER(H_PAPER), .V_PAPER(V_PAPER),
    .H_DE(H_DE), .V_DE(V_DE), .HS_STA(HS_STA), .HS_LEN(HS_LEN),
    .VS_STA(VS_STA), .VS_LEN(VS_LEN), .INT_X(INT_X), .INT_Y(INT_Y),
    .INT_LEN(INT_LEN), .FLASH_DIV(FLASH_DIV), .H_POL(H_POL), .V_POL(V_POL)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .clk_en(clk_en), .mode(mode),
    .mode_act(mode_act), .hsync(hsync), .vsync(vsync), .csync(csync),
    .de(de), .screen(screen), .border(border), .frame(frame), .line(line),
    .int_n(int_n), .flash(flash), .sx(sx), .sy(sy)
  );

  always #5 clk_pix = ~clk_pix;

  out_t exp_q[$];
  int   tests = 0, fails = 0, cyc_mon = 0;
  int   n_frame_rise = 0, n_int_fall = 0, n_flash_tog = 0, n_mode1 = 0;

  // Reference model: linear position within the frame, enabled-cycle timestamps.
  out_t   m_out;
  bit     m_mode, m_tvalid;
  int     m_p, m_frames;
  longint m_en, m_tint;

  function automatic out_t reset_out(input bit md);
    out_t o;
    o = '0;
    o.mode_act = md;
    o.hsync    = (H_POL == 0);
    o.vsync    = (V_POL == 0);
    o.csync    = 1'b1;
    o.int_n    = 1'b1;
    return o;
  endfunction

  task automatic step(input bit r, input bit e, input bit md);
    int ht, vt, x, y;
    bit hs, vs;
    if (!r) begin
      m_mode = md; m_p = 0; m_frames = 0; m_tvalid = 0; m_en = 0; m_tint = 0;
      m_out  = reset_out(md);
    end else if (e) begin
      ht = m_mode ? HT1 : HT0;
      vt = m_mode ? VT1 : VT0;
      x  = m_p % ht;
      y  = m_p / ht;
      hs = (x >= HS_STA) && (x < HS_STA + HS_LEN);
      vs = (y >= VS_STA) && (y < VS_STA + VS_LEN);
      m_out.hsync  = (H_POL != 0) ? hs : !hs;
      m_out.vsync  = (V_POL != 0) ? vs : !vs;
      m_out.csync  = !(hs ^ vs);
      m_out.de     = (x >= H_DE) && (y >= V_DE);
      m_out.screen = (x >= H_PAPER) && (x < H_PAPER + H_RES) &&
                     (y >= V_PAPER) && (y < V_PAPER + V_RES);
      m_out.border = m_out.de && !m_out.screen;
      m_out.frame  = (m_p == 0);
      m_out.line   = (x == 0);
      m_out.sx     = CORDW'(x - H_PAPER);
      m_out.sy     = CORDW'(y - V_PAPER);
      if (x == INT_X && y == INT_Y) begin m_tint = m_en; m_tvalid = 1; end
      m_out.int_n  = !(m_tvalid && (m_en - m_tint) < longint'(INT_LEN));
      if (m_p == 0) m_frames++;
      m_out.flash  = ((m_frames / FLASH_DIV) % 2) == 1;
      m_en++;
      if (m_p == ht * vt - 1) begin m_p = 0; m_mode = md; end
      else m_p++;
      m_out.mode_act = m_mode;
    end
    exp_q.push_back(m_out);
  endtask

  task automatic drive(input bit r, input bit e, input bit md);
    rst_n = r; clk_en = e; mode = md;
    step(r, e, md);
    @(negedge clk_pix);
  endtask

  // Monitor: every edge presents an output word; compare against the queue head.
  always @(posedge clk_pix) begin
    out_t a, e;
    logic pf, pi, pfl;
    pf = frame; pi = int_n; pfl = flash;
    #1;
    cyc_mon++;
    a = {mode_act, hsync, vsync, csync, de, screen, border, frame, line, int_n, flash, sx, sy};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL underflow cycle %0d: output %h with no expectation queued", cyc_mon, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        fails++;
        $display("FAIL outputs cycle %0d: got %h required %h (ma hs vs cs de sc bo fr ln int fl sx sy)",
                 cyc_mon, a, e);
      end
    end
    if (frame && !pf) n_frame_rise++;
    if (!int_n && pi) n_int_fall++;
    if (flash != pfl) n_flash_tog++;
    if (mode_act) n_mode1++;
  end

  initial begin
    bit md, did_rst, r, e;
    md = 0; did_rst = 0;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    for (int c = 0; c < 4000; c++) drive(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 12000; c++) begin
      if (c == 100) md = 1'b1;
      drive(1'b1, (c % 4) == 0, md);
    end
    for (int c = 0; c < 30000; c++) begin
      if (c % 900 == 450) md = ~md;
      r = 1'b1;
      e = ($urandom_range(0, 3) != 0);
      if (!did_rst && m_frames >= 4 && m_tvalid &&
          (m_en - m_tint) > 5 && (m_en - m_tint) < longint'(INT_LEN)) begin
        r = 1'b0; did_rst = 1;
      end
      drive(r, e, md);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    tests++;
    if (n_frame_rise < 25) begin
      fails++; $display("FAIL frame_count: got %0d frame pulses, required >= 25", n_frame_rise);
    end
    tests++;
    if (n_int_fall < 25) begin
      fails++; $display("FAIL int_count: got %0d int_n falls, required >= 25", n_int_fall);
    end
    tests++;
    if (n_flash_tog < 4) begin
      fails++; $display("FAIL flash_toggles: got %0d, required >= 4", n_flash_tog);
    end
    tests++;
    if (n_mode1 == 0 || n_mode1 == cyc_mon) begin
      fails++; $display("FAIL mode_cover: mode_act high %0d of %0d cycles, required both values", n_mode1, cyc_mon);
    end
    tests++;
    if (did_rst == 0) begin
      fails++; $display("FAIL int_reset: got no reset during int_n pulse, required one");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
